// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Index width that stays legal (>=1) even for degenerate counts.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i,
// wrapping N-1 -> 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o
);

  int idx;

  // Scan from the farthest offset down so the nearest eligible index wins last.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (eligible_i[idx]) begin
        any_o    = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with bounded burst ownership sharing one async-FIFO write port;
// grant, w_en and data_in are combinational and always respect full.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_mask,
  input  logic                 full,
  output logic [N-1:0]         gnt,
  output logic                 w_en,
  output logic [WIDTH-1:0]     data_in,
  output logic                 owner_vld,
  output logic [idx_w(N)-1:0]  owner_id,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int IW = idx_w(N);
  localparam int BW = idx_w(BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [N-1:0]     eligible;
  logic [N-1:0]     gnt_c;
  logic             any;
  logic [IW-1:0]    winner;
  logic [WIDTH-1:0] data_c;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + 1'b1;
  endfunction

  assign eligible = req & req_mask;

  rr_pick #(.N(N)) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .any_o      (any),
    .winner_o   (winner)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    gnt_c    = '0;

    if (|eligible && full && (stall_q != '1)) stall_d = stall_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (any && !full) begin
          gnt_c[winner] = 1'b1;
          if (BURST == 1) begin
            rr_ptr_d = inc_wrap(winner);
          end else begin
            owner_d = winner;
            beat_d  = BW'(1);
            state_d = OWN;
          end
        end
      end
      OWN: begin
        if (eligible[owner_q]) begin
          // Owner keeps the lock across full cycles; only a drop releases it early.
          if (!full) begin
            gnt_c[owner_q] = 1'b1;
            beat_d         = beat_q + 1'b1;
            if (beat_q == BW'(BURST - 1)) begin
              rr_ptr_d = inc_wrap(owner_q);
              state_d  = IDLE;
            end
          end
        end else begin
          rr_ptr_d = inc_wrap(owner_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_c = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) data_c = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign gnt       = w_rst ? '0 : gnt_c;
  assign w_en      = |gnt;
  assign data_in   = data_c;
  assign owner_vld = (state_q == OWN);
  assign owner_id  = owner_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: directed producers push expected writes; negedge monitors pop and compare.
module tb_fifo_write_arbiter;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        full;

  logic [3:0]  gnt4, gnt1;
  logic        w_en4, w_en1;
  logic [7:0]  data4, data1;
  logic        ovld4, ovld1;
  logic [1:0]  oid4, oid1;
  logic [15:0] stall4, stall1;

  int checks = 0;
  int passes = 0;

  wr_t        q4[$];
  wr_t        q1[$];
  logic [7:0] src[4][$];
  logic [3:0] gnt_s;
  logic       follow1 = 1'b0;
  logic       m4 = 1'b0;
  logic       m1 = 1'b0;

  always #5 w_clk = ~w_clk;

  fifo_write_arbiter #(.N(4), .WIDTH(8), .BURST(4), .CNT_W(16)) u_dut (
    .w_clk(w_clk), .w_rst(w_rst), .req(req), .req_data(req_data), .req_mask(req_mask),
    .full(full), .gnt(gnt4), .w_en(w_en4), .data_in(data4), .owner_vld(ovld4),
    .owner_id(oid4), .stall_cnt(stall4)
  );

  fifo_write_arbiter #(.N(4), .WIDTH(8), .BURST(1), .CNT_W(16)) u_dut_rr (
    .w_clk(w_clk), .w_rst(w_rst), .req(req), .req_data(req_data), .req_mask(req_mask),
    .full(full), .gnt(gnt1), .w_en(w_en1), .data_in(data1), .owner_vld(ovld1),
    .owner_id(oid1), .stall_cnt(stall1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      req[i]           = (src[i].size() != 0);
      req_data[i*8 +: 8] = (src[i].size() != 0) ? src[i][0] : 8'h00;
    end
  endtask

  // One cycle: producers consume a word only if they saw their grant.
  task automatic tick();
    @(negedge w_clk);
    gnt_s = follow1 ? gnt1 : gnt4;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (gnt_s[i] && src[i].size() != 0) void'(src[i].pop_front());
    refresh();
    #1;
  endtask

  task automatic rst();
    w_rst = 1'b1;
    tick();
    tick();
    w_rst = 1'b0;
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) src[i].delete();
    refresh();
  endtask

  task automatic exp4(input int idx, input logic [7:0] d);
    wr_t e;
    e.idx = idx; e.data = d;
    q4.push_back(e);
  endtask

  always @(negedge w_clk) begin
    wr_t e;
    if (m4) begin
      if (full) chk("no_wen_while_full", 32'(w_en4), 0);
      if (w_en4) begin
        if (q4.size() == 0) chk("unexpected_write", 32'(gnt4), 0);
        else begin
          e = q4.pop_front();
          chk("sb_gnt", 32'(gnt4), 32'(1) << e.idx);
          chk("sb_data", 32'(data4), 32'(e.data));
        end
      end
    end
    if (m1) begin
      if (full) chk("no_wen_while_full_rr", 32'(w_en1), 0);
      if (w_en1) begin
        if (q1.size() == 0) chk("unexpected_write_rr", 32'(gnt1), 0);
        else begin
          e = q1.pop_front();
          chk("sb_gnt_rr", 32'(gnt1), 32'(1) << e.idx);
          chk("sb_data_rr", 32'(data1), 32'(e.data));
        end
      end
    end
  end

  initial begin
    w_rst    = 1'b1;
    full     = 1'b0;
    req_mask = 4'b1111;
    req      = '0;
    req_data = '0;

    // Reset with all requesters asserting
    for (int i = 0; i < 4; i++) src[i].push_back(8'h11);
    refresh();
    tick();
    chk("rst_gnt", 32'(gnt4), 0);
    chk("rst_wen", 32'(w_en4), 0);
    chk("rst_data", 32'(data4), 0);
    chk("rst_stall", 32'(stall4), 0);
    chk("rst_ovld", 32'(ovld4), 0);
    chk("rst_gnt_rr", 32'(gnt1), 0);
    tick();

    // Single requester 2, six words, burst of 4 then re-grant
    clear_src();
    for (int k = 0; k < 6; k++) begin
      src[2].push_back(8'hA0 + 8'(k));
      exp4(2, 8'hA0 + 8'(k));
    end
    refresh();
    m4 = 1'b1;
    rst();
    chk("t2_c0_gnt", 32'(gnt4), 32'h4);
    chk("t2_c0_ovld", 32'(ovld4), 0);
    tick();
    chk("t2_c1_ovld", 32'(ovld4), 1);
    chk("t2_c1_oid", 32'(oid4), 2);
    tick(); tick(); tick();
    chk("t2_c4_idle", 32'(ovld4), 0);
    chk("t2_c4_gnt", 32'(gnt4), 32'h4);
    tick(); tick();
    chk("t2_c6_bubble", 32'(gnt4), 0);
    tick();
    chk("t2_drain", q4.size(), 0);

    // Pure round-robin instance, all four requesting
    m4 = 1'b0;
    clear_src();
    for (int k = 0; k < 8; k++) begin
      wr_t e;
      e.idx  = k % 4;
      e.data = 8'h10 + 8'((k / 4) * 16) + 8'(k % 4);
      src[k % 4].push_back(e.data);
      q1.push_back(e);
    end
    refresh();
    follow1 = 1'b1;
    m1 = 1'b1;
    rst();
    for (int k = 0; k < 8; k++) begin
      chk("t3_rr_gnt", 32'(gnt1), 32'(1) << (k % 4));
      chk("t3_wen", 32'(w_en1), 1);
      tick();
    end
    chk("t3_idle", 32'(gnt1), 0);
    chk("t3_drain", q1.size(), 0);
    m1 = 1'b0;
    follow1 = 1'b0;

    // Requester 1 burst with three full cycles mid-burst
    clear_src();
    for (int k = 0; k < 4; k++) begin
      src[1].push_back(8'h40 + 8'(k));
      exp4(1, 8'h40 + 8'(k));
    end
    refresh();
    m4 = 1'b1;
    rst();
    tick();
    tick();
    full = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_full_wen", 32'(w_en4), 0);
      chk("t4_full_oid", 32'(oid4), 1);
      chk("t4_full_ovld", 32'(ovld4), 1);
      tick();
    end
    full = 1'b0;
    #1;
    chk("t4_stall", 32'(stall4), 3);
    chk("t4_resume", 32'(gnt4), 32'h2);
    tick(); tick();
    chk("t4_done", 32'(ovld4), 0);
    chk("t4_drain", q4.size(), 0);

    // Owner 0 drops after two words; requester 3 follows after a bubble
    clear_src();
    src[0].push_back(8'h50); exp4(0, 8'h50);
    src[0].push_back(8'h51); exp4(0, 8'h51);
    for (int k = 0; k < 4; k++) begin
      src[3].push_back(8'h60 + 8'(k));
      exp4(3, 8'h60 + 8'(k));
    end
    refresh();
    rst();
    tick(); tick();
    chk("t5_bubble_gnt", 32'(gnt4), 0);
    chk("t5_bubble_wen", 32'(w_en4), 0);
    tick();
    chk("t5_next_gnt", 32'(gnt4), 32'h8);
    tick(); tick(); tick(); tick();
    chk("t5_drain", q4.size(), 0);

    // Mask out requester 2, then reset in the middle of requester 3's burst
    clear_src();
    req_mask = 4'b1011;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) src[i].push_back(8'h80 + 8'(i * 16) + 8'(k));
    for (int k = 0; k < 4; k++) exp4(0, 8'h80 + 8'(k));
    for (int k = 0; k < 4; k++) exp4(1, 8'h90 + 8'(k));
    exp4(3, 8'hB0);
    exp4(3, 8'hB1);
    exp4(0, 8'h84);
    refresh();
    rst();
    repeat (10) tick();
    w_rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gnt4), 0);
    tick();
    w_rst = 1'b0;
    #1;
    chk("t6_after_rst_gnt", 32'(gnt4), 32'h1);
    chk("t6_after_rst_ovld", 32'(ovld4), 0);
    tick();
    m4 = 1'b0;
    chk("t6_drain", q4.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
